// File: rtl/fc_outneuron_writer.sv
// rtl/fc_outneuron_writer.sv - drains PO accumulator lanes per group into the FC output neuron RAM (option: FC_RELU_EN)
module fc_outneuron_writer #(
    parameter int OUTNEURON               = 10,
    parameter int PO                      = 2,
    parameter int ACCUM_DATA_WIDTH_FC     = 32,
    parameter int DATA_WIDTH_FC           = 16,
    parameter int FC_OUTNEURON_ADDR_WIDTH = 4,
    parameter int FRAC_SHIFT              = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                accum_valid,
    input  logic [ACCUM_DATA_WIDTH_FC*PO-1:0]   accum_all,
    output logic                                busy,
    output logic                                out_neuron_wren,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]  out_neuron_addr,
    output logic [DATA_WIDTH_FC-1:0]            out_neuron_data,
    output logic                                overflow,
    output logic                                done
);

    localparam int AW     = ACCUM_DATA_WIDTH_FC;
    localparam int DW     = DATA_WIDTH_FC;
    localparam int ADDR_W = FC_OUTNEURON_ADDR_WIDTH;
    localparam int LANE_W = (PO > 1) ? $clog2(PO) : 1;
    localparam int BASE_W = $clog2(OUTNEURON + PO + 1);

    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(PO - 1);
    localparam logic [BASE_W-1:0]    BASE_STEP = BASE_W'(PO);
    localparam logic [BASE_W-1:0]    BASE_END  = BASE_W'(OUTNEURON);
    localparam logic signed [AW-1:0] SAT_MAX   = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN   = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [BASE_W-1:0]   wr_base;
    logic [BASE_W-1:0]   wr_base_next;
    logic [LANE_W-1:0]   lane_idx;
    logic [LANE_W-1:0]   lane_idx_next;
    logic [AW-1:0]       buffer [PO];
    logic                capture;
    logic                wren_next;
    logic [ADDR_W-1:0]   addr_next;
    logic [DW-1:0]       data_next;
    logic                overflow_next;
    logic                done_next;
    logic [BASE_W-1:0]   lane_addr;
    logic [BASE_W-1:0]   base_next;

    // Floor shift back to the stored fixed-point format, then clamp to the signed neuron range.
    function automatic logic [DW-1:0] conv(input logic signed [AW-1:0] x);
        logic signed [AW-1:0] s;
        logic [DW-1:0]        r;
        s = x >>> FRAC_SHIFT;
        if (s > SAT_MAX) begin
            r = {1'b0, {(DW-1){1'b1}}};
        end else if (s < SAT_MIN) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = s[DW-1:0];
        end
`ifdef FC_RELU_EN
        if (r[DW-1]) begin
            r = '0;
        end
`else
        r = r;
`endif
        return r;
    endfunction

    assign lane_addr = wr_base + BASE_W'(lane_idx);
    assign base_next = wr_base + BASE_STEP;
    assign busy      = (state == DRAIN);

    // Next-state and next-output logic; outputs default to hold, write enable defaults low.
    always_comb begin
        state_next    = state;
        wr_base_next  = wr_base;
        lane_idx_next = lane_idx;
        capture       = 1'b0;
        wren_next     = 1'b0;
        addr_next     = out_neuron_addr;
        data_next     = out_neuron_data;
        overflow_next = overflow;
        done_next     = done;
        case (state)
            IDLE: begin
                if (accum_valid && enable) begin
                    capture       = 1'b1;
                    lane_idx_next = '0;
                    state_next    = DRAIN;
                end
            end
            DRAIN: begin
                // A new group cannot be buffered while one is still draining.
                if (accum_valid && enable) begin
                    overflow_next = 1'b1;
                end
                // Lanes past the last neuron of a partial final group are skipped.
                if (lane_addr < BASE_END) begin
                    wren_next = 1'b1;
                    addr_next = ADDR_W'(lane_addr);
                    data_next = conv(buffer[lane_idx]);
                end
                if (lane_idx == LAST_LANE) begin
                    lane_idx_next = '0;
                    wr_base_next  = base_next;
                    if (base_next >= BASE_END) begin
                        state_next = FIN;
                        done_next  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    lane_idx_next = lane_idx + LANE_W'(1);
                end
            end
            FIN: begin
                done_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters and registered RAM-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            wr_base         <= '0;
            lane_idx        <= '0;
            out_neuron_wren <= 1'b0;
            out_neuron_addr <= '0;
            out_neuron_data <= '0;
            overflow        <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_next;
            wr_base         <= wr_base_next;
            lane_idx        <= lane_idx_next;
            out_neuron_wren <= wren_next;
            out_neuron_addr <= addr_next;
            out_neuron_data <= data_next;
            overflow        <= overflow_next;
            done            <= done_next;
        end
    end

    // Lane buffer: snapshot of the whole group so the accumulators are free immediately.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < PO; p++) begin
                buffer[p] <= '0;
            end
        end else if (capture) begin
            for (int p = 0; p < PO; p++) begin
                buffer[p] <= accum_all[p*AW +: AW];
            end
        end
    end

endmodule

// File: tb/tb_fc_outneuron_writer.sv
// tb/tb_fc_outneuron_writer.sv - directed self-checking bench for fc_outneuron_writer
module tb_fc_outneuron_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        accum_valid;
    logic [63:0] accum_all;
    logic        busy;
    logic        out_neuron_wren;
    logic [3:0]  out_neuron_addr;
    logic [15:0] out_neuron_data;
    logic        overflow;
    logic        done;

    int tests = 0;
    int fails = 0;

    fc_outneuron_writer dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .accum_valid     (accum_valid),
        .accum_all       (accum_all),
        .busy            (busy),
        .out_neuron_wren (out_neuron_wren),
        .out_neuron_addr (out_neuron_addr),
        .out_neuron_data (out_neuron_data),
        .overflow        (overflow),
        .done            (done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic wr, input logic [3:0] a,
                            input logic [15:0] d, input logic b);
        chk({tag, ".wren"}, {31'd0, out_neuron_wren}, {31'd0, wr});
        chk({tag, ".addr"}, {28'd0, out_neuron_addr}, {28'd0, a});
        chk({tag, ".data"}, {16'd0, out_neuron_data}, {16'd0, d});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    // One group: valid edge N, lane writes visible after N+1 and N+2, idle after N+3.
    task automatic run_group(input string tag, input logic [31:0] l0, input logic [31:0] l1,
                             input logic [3:0] a0, input logic [15:0] d0,
                             input logic [15:0] d1, input logic exp_done);
        accum_all   = {l1, l0};
        accum_valid = 1'b1;
        enable      = 1'b1;
        step();
        accum_valid = 1'b0;
        chk({tag, ".n0.busy"}, {31'd0, busy}, 32'd1);
        chk({tag, ".n0.wren"}, {31'd0, out_neuron_wren}, 32'd0);
        step();
        chk_outs({tag, ".lane0"}, 1'b1, a0, d0, 1'b1);
        step();
        chk_outs({tag, ".lane1"}, 1'b1, a0 + 4'd1, d1, 1'b0);
        chk({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
        step();
        chk_outs({tag, ".hold"}, 1'b0, a0 + 4'd1, d1, 1'b0);
    endtask

    logic [15:0] exp_min;
    logic [15:0] exp_neg2;

    initial begin
`ifdef FC_RELU_EN
        exp_min  = 16'h0000;
        exp_neg2 = 16'h0000;
`else
        exp_min  = 16'h8000;
        exp_neg2 = 16'hFFFE;
`endif
        reset       = 1'b1;
        enable      = 1'b0;
        accum_valid = 1'b0;
        accum_all   = '0;
        step();
        step();
        chk_outs("reset", 1'b0, 4'd0, 16'd0, 1'b0);
        chk("reset.overflow", {31'd0, overflow}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        step();

        // Basic conversion, addresses 0 and 1.
        run_group("basic", 32'h0000_0300, 32'h0000_0480, 4'd0, 16'h0003, 16'h0004, 1'b0);

        // Saturation and negative handling, addresses 2..5.
        run_group("sat", 32'h7FFF_FFFF, 32'h8000_0000, 4'd2, 16'h7FFF, exp_min, 1'b0);
        run_group("neg", 32'hFFFF_FE00, 32'h0000_0100, 4'd4, exp_neg2, 16'h0001, 1'b0);

        // enable low: request ignored, no overflow.
        accum_all   = {32'h0000_0900, 32'h0000_0A00};
        accum_valid = 1'b1;
        enable      = 1'b0;
        step();
        accum_valid = 1'b0;
        chk_outs("dis.n0", 1'b0, 4'd5, 16'h0001, 1'b0);
        step();
        chk_outs("dis.n1", 1'b0, 4'd5, 16'h0001, 1'b0);
        chk("dis.overflow", {31'd0, overflow}, 32'd0);

        // Back-to-back requests: second dropped, overflow sticky, addresses 6,7.
        accum_all   = {32'h0000_0700, 32'h0000_0600};
        accum_valid = 1'b1;
        enable      = 1'b1;
        step();
        chk("ovf.n0.overflow", {31'd0, overflow}, 32'd0);
        accum_all = {32'h0000_0B00, 32'h0000_0C00};
        step();
        accum_valid = 1'b0;
        chk_outs("ovf.lane0", 1'b1, 4'd6, 16'h0006, 1'b1);
        step();
        chk_outs("ovf.lane1", 1'b1, 4'd7, 16'h0007, 1'b0);
        chk("ovf.n2.overflow", {31'd0, overflow}, 32'd1);
        step();
        chk_outs("ovf.n3", 1'b0, 4'd7, 16'h0007, 1'b0);
        step();
        chk_outs("ovf.n4", 1'b0, 4'd7, 16'h0007, 1'b0);
        chk("ovf.sticky", {31'd0, overflow}, 32'd1);

        // Reset one edge into a drain: aborted, everything cleared.
        accum_all   = {32'h0000_0D00, 32'h0000_0E00};
        accum_valid = 1'b1;
        step();
        accum_valid = 1'b0;
        reset       = 1'b1;
        step();
        chk_outs("rst.n1", 1'b0, 4'd0, 16'd0, 1'b0);
        chk("rst.overflow", {31'd0, overflow}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        step();
        chk_outs("rst.n2", 1'b0, 4'd0, 16'd0, 1'b0);

        // Five groups fill addresses 0..9; done only with the 10th write.
        for (int g = 0; g < 5; g++) begin
            run_group($sformatf("fill%0d", g),
                      (32'(2*g) + 32'h10) << 8, (32'(2*g) + 32'h11) << 8,
                      4'(2*g), 16'(2*g + 16), 16'(2*g + 17), (g == 4));
        end

        // Request after completion: no write, no overflow, done held.
        accum_all   = {32'h0000_0F00, 32'h0000_0F00};
        accum_valid = 1'b1;
        step();
        accum_valid = 1'b0;
        chk_outs("fin.n0", 1'b0, 4'd9, 16'h0019, 1'b0);
        step();
        chk_outs("fin.n1", 1'b0, 4'd9, 16'h0019, 1'b0);
        chk("fin.overflow", {31'd0, overflow}, 32'd0);
        chk("fin.done", {31'd0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
